// File: rtl/vram_sync_pkg.sv
// -----------------------------------------------------------------------------
// vram_sync_pkg
//   Shared types and constants for the VRAM bank synchroniser.
//   - state_e   : copier FSM states (IDLE -> TIL -> PAT -> PAL -> SPR -> DRAIN)
//   - SEL_*     : one-hot RAM selects, bit order {spr,pal,pat,til}
//   - rd_tag_t  : {valid, sel, addr} tag carried alongside a source read
//   - helpers   : state -> one-hot select, and "next RAM to copy" lookup
// -----------------------------------------------------------------------------
package vram_sync_pkg;

    // Width of the address field inside a read tag. The copier's AW must not
    // exceed this; the default AW equals it so no tag bits go to waste.
    localparam int TAG_AW = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TIL   = 3'd1,
        PAT   = 3'd2,
        PAL   = 3'd3,
        SPR   = 3'd4,
        DRAIN = 3'd5
    } state_e;

    localparam logic [3:0] SEL_TIL = 4'b0001;
    localparam logic [3:0] SEL_PAT = 4'b0010;
    localparam logic [3:0] SEL_PAL = 4'b0100;
    localparam logic [3:0] SEL_SPR = 4'b1000;

    typedef struct packed {
        logic              valid;
        logic [3:0]        sel;
        logic [TAG_AW-1:0] addr;
    } rd_tag_t;

    // One-hot RAM select for a copy state; zero for IDLE/DRAIN.
    function automatic logic [3:0] state_sel(input state_e s);
        logic [3:0] sel;
        case (s)
            TIL:     sel = SEL_TIL;
            PAT:     sel = SEL_PAT;
            PAL:     sel = SEL_PAL;
            SPR:     sel = SEL_SPR;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // First copy state whose RAM index is >= from_idx and whose mask bit is
    // set; DRAIN when none remain. RAM index 0..3 = til, pat, pal, spr.
    // Because the state encoding TIL..SPR is 1..4, passing the current copy
    // state's encoding as from_idx yields the RAM that follows it.
    function automatic state_e first_copy_state(input logic [2:0] from_idx,
                                                input logic [3:0] mask);
        state_e s;
        if (from_idx == 3'd0 && mask[0]) begin
            s = TIL;
        end else if (from_idx <= 3'd1 && mask[1]) begin
            s = PAT;
        end else if (from_idx <= 3'd2 && mask[2]) begin
            s = PAL;
        end else if (from_idx <= 3'd3 && mask[3]) begin
            s = SPR;
        end else begin
            s = DRAIN;
        end
        return s;
    endfunction

endpackage

// File: rtl/vram_sync_delay.sv
// -----------------------------------------------------------------------------
// vram_sync_delay
//   RD_LAT-deep shift register of read tags. It tracks each source read so
//   that the matching destination write is issued exactly when the source
//   RAM's q is valid.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset; flushes every stage
//   din   in   tag for the read issued this cycle
//   dout  out  tag for the read issued RD_LAT cycles ago
// -----------------------------------------------------------------------------
module vram_sync_delay
    import vram_sync_pkg::*;
#(
    parameter int RD_LAT = 2
)
(
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t din,
    output rd_tag_t dout
);

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        rd_tag_t q_reg;

        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= din;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    end

    assign dout = g_stage[RD_LAT-1].q_reg;

endmodule

// File: rtl/vram_sync_copier.sv
// -----------------------------------------------------------------------------
// vram_sync_copier
//   Copies the CPU-facing VRAM bank (tile, pattern, palette, sprite RAMs) into
//   the PPU-facing bank once per vblank. Source reads stream back-to-back
//   through all four RAMs with no bubbles; each read's {sel,addr} travels
//   through an RD_LAT-deep tag pipe so the destination write lines up with
//   the source q.
//
//   Optional build macro: VRAM_SYNC_DIRTY_EN
//     defined   : dirty[3:0] is sampled when start is accepted and RAMs whose
//                 bit is clear are skipped in zero cycles.
//     undefined : dirty is ignored; all four RAMs are always copied.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active high
//   start       in   vblank pulse; requests one full sync (ignored while busy)
//   busy        out  high from the cycle after an accepted start until done
//   done        out  one-cycle pulse alongside the last destination write
//   cpu_lock    out  same as busy; stalls CPU-side VRAM writes
//   src_sel     out  one-hot source RAM select {spr,pal,pat,til}
//   src_addr    out  source port-A read address
//   src_rddata  in   source q, valid RD_LAT cycles after src_addr
//   dst_sel     out  one-hot destination RAM select
//   dst_addr    out  destination port-A write address
//   dst_wrdata  out  destination write data (src_rddata passed through)
//   dst_wren    out  destination write enable
//   dirty       in   per-RAM modified flags (only with VRAM_SYNC_DIRTY_EN)
//
// RD_LAT legal range is 1..4; AW must cover the deepest RAM and must not
// exceed vram_sync_pkg::TAG_AW.
// -----------------------------------------------------------------------------
module vram_sync_copier
    import vram_sync_pkg::*;
#(
    parameter int DW        = 64,
    parameter int AW        = TAG_AW,
    parameter int TIL_DEPTH = 2048,
    parameter int PAT_DEPTH = 4096,
    parameter int PAL_DEPTH = 512,
    parameter int SPR_DEPTH = 256,
    parameter int RD_LAT    = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cpu_lock,
    output logic [3:0]    src_sel,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_rddata,
    output logic [3:0]    dst_sel,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_wrdata,
    output logic          dst_wren,
    input  logic [3:0]    dirty
);

    // Last address of each RAM, and the last DRAIN count.
    localparam logic [AW-1:0] TIL_LAST   = AW'(TIL_DEPTH - 1);
    localparam logic [AW-1:0] PAT_LAST   = AW'(PAT_DEPTH - 1);
    localparam logic [AW-1:0] PAL_LAST   = AW'(PAL_DEPTH - 1);
    localparam logic [AW-1:0] SPR_LAST   = AW'(SPR_DEPTH - 1);
    localparam logic [AW-1:0] DRAIN_LAST = AW'(RD_LAT - 1);

    state_e        state_reg, state_next;
    // Address counter in copy states, drain-cycle counter in DRAIN.
    logic [AW-1:0] cnt_reg, cnt_next;
    logic [AW-1:0] last_addr;
    logic          copying;

    // RAM enable masks: start_mask chooses the first RAM at acceptance,
    // run_mask chooses the following ones during the sync.
    logic [3:0]    start_mask;
    logic [3:0]    run_mask;

    rd_tag_t       tag_in;
    rd_tag_t       tag_out;

`ifdef VRAM_SYNC_DIRTY_EN
    // Snapshot of dirty taken when start is accepted; upstream clears its
    // flags on done, so the live input cannot be trusted mid-sync.
    logic [3:0] dirty_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_reg <= 4'b0000;
        end else if (state_reg == IDLE && start) begin
            dirty_reg <= dirty;
        end
    end

    assign start_mask = dirty;
    assign run_mask   = dirty_reg;
`else
    logic unused_dirty;

    assign unused_dirty = ^dirty;
    assign start_mask   = 4'b1111;
    assign run_mask     = 4'b1111;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        last_addr = '0;
        case (state_reg)
            TIL:     last_addr = TIL_LAST;
            PAT:     last_addr = PAT_LAST;
            PAL:     last_addr = PAL_LAST;
            SPR:     last_addr = SPR_LAST;
            default: last_addr = '0;
        endcase
    end

    assign copying = (state_reg == TIL) || (state_reg == PAT) ||
                     (state_reg == PAL) || (state_reg == SPR);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = first_copy_state(3'd0, start_mask);
                end
            end
            TIL, PAT, PAL, SPR: begin
                if (cnt_reg == last_addr) begin
                    // Next RAM starts on the very next cycle: no bubble.
                    cnt_next   = '0;
                    state_next = first_copy_state(state_reg, run_mask);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Source side and status
    // ------------------------------------------------------------------
    assign src_sel  = state_sel(state_reg);
    assign src_addr = copying ? cnt_reg : '0;
    assign busy     = (state_reg != IDLE);
    assign cpu_lock = busy;
    // The last write leaves the tag pipe in the final DRAIN cycle.
    assign done     = (state_reg == DRAIN) && (cnt_reg == DRAIN_LAST);

    // ------------------------------------------------------------------
    // Read tag pipeline and destination side
    // ------------------------------------------------------------------
    always_comb begin
        tag_in       = '0;
        tag_in.valid = copying;
        tag_in.sel   = src_sel;
        tag_in.addr  = TAG_AW'(src_addr);
    end

    vram_sync_delay #(
        .RD_LAT (RD_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    // Invalid tags carry zero sel/addr, so only the data needs gating.
    assign dst_wren   = tag_out.valid;
    assign dst_sel    = tag_out.sel;
    assign dst_addr   = AW'(tag_out.addr);
    assign dst_wrdata = tag_out.valid ? src_rddata : '0;

endmodule

// File: tb/tb_vram_sync_copier.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vram_sync_copier
//   Three copiers (RD_LAT = 1, 2, 4) share one stimulus stream. A reference
//   model turns each accepted start into a list of expected reads, writes and
//   a done cycle; a monitor compares every output of every DUT each cycle.
// -----------------------------------------------------------------------------
module tb_vram_sync_copier;

    localparam int DW   = 64;
    localparam int AW   = 12;
    localparam int NDUT = 3;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int depth_of(input int r);
        case (r)
            0:       return 4;   // tile
            1:       return 8;   // pattern
            2:       return 2;   // palette
            default: return 2;   // sprite
        endcase
    endfunction

    typedef struct {
        int            cyc;
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    dirty;

    logic [NDUT-1:0] busy_w, done_w, lock_w, wren_w;
    logic [3:0]      src_sel_w  [NDUT];
    logic [3:0]      dst_sel_w  [NDUT];
    logic [AW-1:0]   src_addr_w [NDUT];
    logic [AW-1:0]   dst_addr_w [NDUT];
    logic [DW-1:0]   rddata_w   [NDUT];
    logic [DW-1:0]   wrdata_w   [NDUT];

    // Source RAM contents: random upper bits, then {sel, addr} in the low 16.
    logic [47:0] mem [4][8];

    ev_t rq [NDUT][$];
    ev_t wq [NDUT][$];
    int  dq [NDUT][$];
    int  bs [NDUT];
    int  be [NDUT];
    int  cyc;
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [3:0] sel, input logic [AW-1:0] addr);
        logic [DW-1:0] w;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            if (sel == 4'(1 << r)) w = {mem[r][addr[2:0]], sel, addr};
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // DUTs with their source RAM models
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int L = lat_of(gi);
        logic [DW-1:0] data_pipe [L];

        always_ff @(posedge clk) begin
            data_pipe[0] <= ram_word(src_sel_w[gi], src_addr_w[gi]);
            for (int k = 1; k < L; k++) data_pipe[k] <= data_pipe[k-1];
        end

        assign rddata_w[gi] = data_pipe[L-1];

        vram_sync_copier #(
            .DW(DW), .AW(AW),
            .TIL_DEPTH(4), .PAT_DEPTH(8), .PAL_DEPTH(2), .SPR_DEPTH(2),
            .RD_LAT(L)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .busy       (busy_w[gi]),
            .done       (done_w[gi]),
            .cpu_lock   (lock_w[gi]),
            .src_sel    (src_sel_w[gi]),
            .src_addr   (src_addr_w[gi]),
            .src_rddata (rddata_w[gi]),
            .dst_sel    (dst_sel_w[gi]),
            .dst_addr   (dst_addr_w[gi]),
            .dst_wrdata (wrdata_w[gi]),
            .dst_wren   (wren_w[gi]),
            .dirty      (dirty)
        );
    end

    // ------------------------------------------------------------------
    // Reference model: an accepted start at cycle c issues one read per
    // cycle from c+1 over every enabled RAM in order, each write RD_LAT
    // later, and done with busy dropping after the last write.
    // ------------------------------------------------------------------
    task automatic schedule(input int d, input int c, input logic [3:0] m);
        int  k;
        ev_t e;
        k = 0;
        for (int r = 0; r < 4; r++) begin
            if (m[r]) begin
                for (int a = 0; a < depth_of(r); a++) begin
                    e.sel  = 4'(1 << r);
                    e.addr = AW'(a);
                    e.cyc  = c + 1 + k;
                    e.data = '0;
                    rq[d].push_back(e);
                    e.cyc  = c + 1 + k + lat_of(d);
                    e.data = ram_word(e.sel, e.addr);
                    wq[d].push_back(e);
                    k++;
                end
            end
        end
        bs[d] = c + 1;
        be[d] = c + k + lat_of(d);
        dq[d].push_back(be[d]);
    endtask

    initial begin : model
        logic [3:0] m;
        cyc = 0;
        for (int d = 0; d < NDUT; d++) begin
            bs[d] = 1;
            be[d] = 0;
        end
        forever begin
            @(posedge clk);
`ifdef VRAM_SYNC_DIRTY_EN
            m = dirty;
`else
            m = 4'hF;
`endif
            for (int d = 0; d < NDUT; d++) begin
                if (rst) begin
                    while (rq[d].size() > 0 && rq[d][rq[d].size()-1].cyc > cyc)
                        rq[d].delete(rq[d].size()-1);
                    while (wq[d].size() > 0 && wq[d][wq[d].size()-1].cyc > cyc)
                        wq[d].delete(wq[d].size()-1);
                    while (dq[d].size() > 0 && dq[d][dq[d].size()-1] > cyc)
                        dq[d].delete(dq[d].size()-1);
                    if (be[d] > cyc) be[d] = cyc;
                end else if (start && !(cyc >= bs[d] && cyc <= be[d])) begin
                    schedule(d, cyc, m);
                end
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d(RD_LAT=%0d) cycle %0d: got %0h expected %0h",
                     name, d, lat_of(d), cyc, act, exp);
        end
    endtask

    task automatic check_cycle(input int d);
        ev_t  er, ew;
        logic exp_rd, exp_wr, exp_done, exp_busy;
        er.cyc = 0; er.sel = '0; er.addr = '0; er.data = '0;
        ew = er;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        exp_done = 1'b0;
        if (rq[d].size() > 0 && rq[d][0].cyc == cyc) begin
            er = rq[d].pop_front();
            exp_rd = 1'b1;
        end
        if (wq[d].size() > 0 && wq[d][0].cyc == cyc) begin
            ew = wq[d].pop_front();
            exp_wr = 1'b1;
        end
        if (dq[d].size() > 0 && dq[d][0] == cyc) begin
            void'(dq[d].pop_front());
            exp_done = 1'b1;
        end
        exp_busy = (cyc >= bs[d]) && (cyc <= be[d]);

        check("busy",       d, 64'(busy_w[d]),     64'(exp_busy));
        check("cpu_lock",   d, 64'(lock_w[d]),     64'(exp_busy));
        check("done",       d, 64'(done_w[d]),     64'(exp_done));
        check("src_sel",    d, 64'(src_sel_w[d]),  64'(exp_rd ? er.sel : 4'b0000));
        check("src_addr",   d, 64'(src_addr_w[d]), 64'(er.addr));
        check("dst_wren",   d, 64'(wren_w[d]),     64'(exp_wr));
        check("dst_sel",    d, 64'(dst_sel_w[d]),  64'(ew.sel));
        check("dst_addr",   d, 64'(dst_addr_w[d]), 64'(ew.addr));
        if (exp_wr) check("dst_wrdata", d, wrdata_w[d], ew.data);
        if (exp_done)
            $display("dut%0d RD_LAT=%0d sync complete at cycle %0d (busy %0d cycles)",
                     d, lat_of(d), cyc, be[d] - bs[d] + 1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int d = 0; d < NDUT; d++) check_cycle(d);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [63:0] t;
        rst   = 1'b1;
        start = 1'b0;
        dirty = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 8; a++) begin
                t = {$urandom(), $urandom()};
                mem[r][a] = t[47:0];
            end
        end
        tick(3);
        rst = 1'b0;
        tick(3);

        // single sync (tile + palette only when dirty masking is built in)
        dirty = 4'b0101;
        start = 1'b1; tick(1); start = 1'b0;
        tick(30);

        // full sync, second start 5 cycles into busy must be ignored
        dirty = 4'hF;
        start = 1'b1; tick(1); start = 1'b0;
        tick(4);
        start = 1'b1; tick(1); start = 1'b0;
        tick(30);

        // empty dirty mask
        dirty = 4'h0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(10);

        // reset 7 cycles into a copy, then a fresh full copy
        dirty = 4'hF;
        start = 1'b1; tick(1); start = 1'b0;
        tick(6);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(5);
        start = 1'b1; tick(1); start = 1'b0;
        tick(30);

        // start held high: back-to-back syncs
        start = 1'b1; tick(70); start = 1'b0;
        tick(30);

        // random starts, dirty masks and occasional resets
        for (int i = 0; i < 60; i++) begin
            dirty = 4'($urandom());
            start = ($urandom_range(0, 2) != 0);
            rst   = ($urandom_range(0, 24) == 0);
            tick(1);
            start = 1'b0;
            rst   = 1'b0;
            tick($urandom_range(0, 25));
        end
        tick(40);

        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (rq[d].size() + wq[d].size() + dq[d].size() != 0) begin
                n_err++;
                $display("FAIL pending dut%0d: got %0d outstanding events expected 0",
                         d, rq[d].size() + wq[d].size() + dq[d].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
